ccsds_turbo_enc_source: RTL and testbench

//  Input framer in front of the encoder nD RAM buffer. Accepts a sop/eop framed word stream and the

---
 rtl/ccsds_turbo_enc_pkg.sv | 11 +
 rtl/ccsds_turbo_enc_source.sv | 176 +++++++++++++++++
 tb/tb_ccsds_turbo_enc_source.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ccsds_turbo_enc_pkg.sv
// Shared types for the CCSDS turbo encoder front end.
package ccsds_turbo_enc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_PAD   = 2'd2,
        ST_DROP  = 2'd3
    } state_t;

endpackage

// File: rtl/ccsds_turbo_enc_source.sv
// Input framer for the encoder buffer: forces exactly N words per frame by
// padding short frames with zeros and dropping the surplus of long ones.
module ccsds_turbo_enc_source
    import ccsds_turbo_enc_pkg::*;
#(
    parameter int unsigned pADDR_W = 8,
    parameter int unsigned pDATA_W = 8,
    parameter int unsigned pTAG_W  = 8
) (
    input  logic               iclk,
    input  logic               ireset,
    input  logic               iclkena,
    input  logic [pADDR_W:0]   iN,
    input  logic               isop,
    input  logic               ival,
    input  logic               ieop,
    input  logic [pDATA_W-1:0] idat,
    input  logic [pTAG_W-1:0]  itag,
    output logic               ordy,
    input  logic               ifulla,
    output logic               owrite,
    output logic [pADDR_W-1:0] owaddr,
    output logic [pDATA_W-1:0] owdata,
    output logic               owfull,
    output logic [pTAG_W-1:0]  owtag,
    output logic               obusy,
    output logic               oerr
);

    localparam int unsigned CNT_W = pADDR_W + 1;
    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(2 ** pADDR_W);

    state_t               r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0]     r_n, w_n_nxt;
    logic [pTAG_W-1:0]    r_tag, w_tag_nxt;

    logic                 r_write, r_full, r_err;
    logic [pADDR_W-1:0]   r_waddr;
    logic [pDATA_W-1:0]   r_wdata;
    logic [pTAG_W-1:0]    r_otag;

    logic                 w_acc, w_last, w_n_ok;
    logic                 w_write, w_full, w_err;
    logic [pADDR_W-1:0]   w_waddr;
    logic [pDATA_W-1:0]   w_wdata;
    logic [pTAG_W-1:0]    w_otag;

    // A started frame owns its bank, so ifulla only gates the IDLE state.
    assign ordy   = ((r_state == ST_IDLE) & ~ifulla) | (r_state == ST_WRITE) | (r_state == ST_DROP);
    assign w_acc  = ival & ordy;
    assign w_last = (r_cnt == (r_n - CNT_W'(1)));
    assign w_n_ok = (iN != '0) && (iN <= MAX_N);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_n_nxt     = r_n;
        w_tag_nxt   = r_tag;
        w_write     = 1'b0;
        w_full      = 1'b0;
        w_err       = 1'b0;
        w_waddr     = r_cnt[pADDR_W-1:0];
        w_wdata     = idat;
        w_otag      = r_otag;
        case (r_state)
            ST_IDLE: begin
                if (w_acc) begin
                    if (!isop) begin
                        w_err = 1'b1;
                    end else if (!w_n_ok) begin
                        w_err = 1'b1;
                        if (!ieop) w_state_nxt = ST_DROP;
                    end else begin
                        w_n_nxt   = iN;
                        w_tag_nxt = itag;
                        w_write   = 1'b1;
                        w_waddr   = '0;
                        w_cnt_nxt = CNT_W'(1);
                        if (iN == CNT_W'(1)) begin
                            w_full = 1'b1;
                            w_otag = itag;
                            if (!ieop) begin
                                w_err       = 1'b1;
                                w_state_nxt = ST_DROP;
                            end
                        end else if (ieop) begin
                            w_err       = 1'b1;
                            w_state_nxt = ST_PAD;
                        end else begin
                            w_state_nxt = ST_WRITE;
                        end
                    end
                end
            end
            ST_WRITE: begin
                if (w_acc) begin
                    w_write   = 1'b1;
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    w_err     = isop;
                    if (w_last) begin
                        w_full = 1'b1;
                        w_otag = r_tag;
                        if (ieop) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_err       = 1'b1;
                            w_state_nxt = ST_DROP;
                        end
                    end else if (ieop) begin
                        w_err       = 1'b1;
                        w_state_nxt = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                w_write   = 1'b1;
                w_wdata   = '0;
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (w_last) begin
                    w_full      = 1'b1;
                    w_otag      = r_tag;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (w_acc && ieop) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_n     <= '0;
            r_tag   <= '0;
        end else if (iclkena) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_n     <= w_n_nxt;
            r_tag   <= w_tag_nxt;
        end
    end

    // Registered buffer interface; address/data only move on a write.
    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            r_write <= 1'b0;
            r_full  <= 1'b0;
            r_err   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_otag  <= '0;
        end else if (iclkena) begin
            r_write <= w_write;
            r_full  <= w_full;
            r_err   <= w_err;
            r_otag  <= w_otag;
            if (w_write) begin
                r_waddr <= w_waddr;
                r_wdata <= w_wdata;
            end
        end
    end

    assign owrite = r_write;
    assign owaddr = r_waddr;
    assign owdata = r_wdata;
    assign owfull = r_full;
    assign owtag  = r_otag;
    assign oerr   = r_err;
    assign obusy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ccsds_turbo_enc_source.sv
// Self-checking bench for ccsds_turbo_enc_source: directed scenarios plus
// random frames checked against a frame-level model of the write stream.
module tb_ccsds_turbo_enc_source;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned TW = 8;

    logic          iclk = 1'b0;
    logic          ireset, iclkena, isop, ival, ieop, ifulla;
    logic [AW:0]   iN;
    logic [DW-1:0] idat;
    logic [TW-1:0] itag;
    logic          ordy, owrite, owfull, obusy, oerr;
    logic [AW-1:0] owaddr;
    logic [DW-1:0] owdata;
    logic [TW-1:0] owtag;

    always #5 iclk = ~iclk;

    ccsds_turbo_enc_source #(.pADDR_W(AW), .pDATA_W(DW), .pTAG_W(TW)) dut (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .iN(iN), .isop(isop),
        .ival(ival), .ieop(ieop), .idat(idat), .itag(itag), .ordy(ordy),
        .ifulla(ifulla), .owrite(owrite), .owaddr(owaddr), .owdata(owdata),
        .owfull(owfull), .owtag(owtag), .obusy(obusy), .oerr(oerr)
    );

    typedef struct {
        int wr;
        int addr;
        int data;
        int full;
        int tag;
    } wr_t;

    wr_t           exp_q[$];
    wr_t           got_q[$];
    logic [DW-1:0] cur_d[$];
    int            mon_err  = 0;
    int            exp_err  = 0;
    int            last_tag = 0;
    int            n_vec    = 0;
    int            n_err    = 0;

    // Record buffer-side events produced by each enabled, out-of-reset edge.
    initial begin
        forever begin
            bit en;
            @(posedge iclk);
            en = iclkena && ireset;
            @(negedge iclk);
            if (en) begin
                if (owrite || owfull)
                    got_q.push_back('{int'(owrite), int'(owaddr), int'(owdata), int'(owfull), int'(owtag)});
                if (oerr) mon_err++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input bit sop, input bit eop, input logic [DW-1:0] d,
                             input int n, input logic [TW-1:0] tg, input bit rnd_en);
        int budget = 0;
        bit done   = 1'b0;
        isop = sop; ieop = eop; idat = d; iN = (AW+1)'(n); itag = tg; ival = 1'b1;
        while (!done) begin
            iclkena = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (ordy && iclkena) done = 1'b1;
            @(posedge iclk);
            @(negedge iclk);
            if (!done) begin
                budget++;
                if (budget > 2000) begin
                    n_vec++;
                    n_err++;
                    $error("FAIL send_timeout observed=%0d expected<=2000", budget);
                    done = 1'b1;
                end
            end
        end
        ival = 1'b0; isop = 1'b0; ieop = 1'b0;
        iclkena = 1'b1;
    endtask

    // Frame-level model: exactly n writes, data then zero padding, commit on the last.
    task automatic build_expected(input int n, input int len, input int tg);
        if (n < 1 || n > (1 << AW)) begin
            exp_err++;
        end else begin
            for (int i = 0; i < n; i++) begin
                int d;
                d = (i < len) ? int'(cur_d[i]) : 0;
                exp_q.push_back('{1, i % (1 << AW), d, int'(i == n - 1), (i == n - 1) ? tg : last_tag});
            end
            last_tag = tg;
            if (len != n) exp_err++;
        end
    endtask

    task automatic drain();
        int idle = 0;
        int cyc  = 0;
        ival = 1'b0; iclkena = 1'b1;
        while (idle < 2 && cyc < 1000) begin
            @(posedge iclk);
            @(negedge iclk);
            idle = obusy ? 0 : idle + 1;
            cyc++;
        end
        chk("drain_idle", 32'(obusy), 32'd0);
    endtask

    task automatic check_frames(input string name);
        int m;
        chk({name, "_wrcount"}, 32'(got_q.size()), 32'(exp_q.size()));
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            chk({name, "_wr"},   32'(got_q[i].wr),   32'(exp_q[i].wr));
            chk({name, "_addr"}, 32'(got_q[i].addr), 32'(exp_q[i].addr));
            chk({name, "_data"}, 32'(got_q[i].data), 32'(exp_q[i].data));
            chk({name, "_full"}, 32'(got_q[i].full), 32'(exp_q[i].full));
            chk({name, "_tag"},  32'(got_q[i].tag),  32'(exp_q[i].tag));
        end
        chk({name, "_errcount"}, 32'(mon_err), 32'(exp_err));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic send_frame(input string name, input int n, input int len,
                              input int tg, input bit rnd_en);
        for (int i = 0; i < len; i++)
            send_word(i == 0, i == len - 1, cur_d[i], n, TW'(tg), rnd_en);
        build_expected(n, len, tg);
        drain();
        check_frames(name);
    endtask

    initial begin
        ireset = 1'b0; iclkena = 1'b1; isop = 1'b0; ival = 1'b0; ieop = 1'b0;
        ifulla = 1'b0; iN = '0; idat = '0; itag = '0;
        repeat (3) @(negedge iclk);
        #1;
        chk("rst_owrite", 32'(owrite), 32'd0);
        chk("rst_owaddr", 32'(owaddr), 32'd0);
        chk("rst_owdata", 32'(owdata), 32'd0);
        chk("rst_owfull", 32'(owfull), 32'd0);
        chk("rst_owtag",  32'(owtag),  32'd0);
        chk("rst_obusy",  32'(obusy),  32'd0);
        chk("rst_oerr",   32'(oerr),   32'd0);
        chk("rst_ordy",   32'(ordy),   32'd1);
        @(negedge iclk);
        ireset = 1'b1;
        @(negedge iclk);

        // Exact-length frame
        cur_d = {8'hA0, 8'hA1, 8'hA2, 8'hA3};
        send_frame("t1", 4, 4, 8'h5A, 1'b0);

        // Short frame padded, ordy low during the three pad cycles
        cur_d = {8'h31, 8'h32, 8'h33};
        for (int i = 0; i < 3; i++) send_word(i == 0, i == 2, cur_d[i], 6, 8'h66, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t2_ordy_pad", 32'(ordy), 32'd0);
            @(posedge iclk);
            @(negedge iclk);
        end
        #1;
        chk("t2_ordy_idle", 32'(ordy), 32'd1);
        build_expected(6, 3, 8'h66);
        drain();
        check_frames("t2");

        // Long frame, surplus dropped
        cur_d = {8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
        send_frame("t3", 3, 5, 8'h33, 1'b0);

        // ifulla holds off a pending sop
        ifulla = 1'b1;
        isop = 1'b1; ieop = 1'b0; ival = 1'b1; idat = 8'h51; iN = 9'd2; itag = 8'h44;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t4_ordy_full", 32'(ordy), 32'd0);
            @(posedge iclk);
            @(negedge iclk);
        end
        chk("t4_no_write", 32'(got_q.size()), 32'd0);
        ifulla = 1'b0;
        cur_d = {8'h51, 8'h52};
        send_frame("t4", 2, 2, 8'h44, 1'b0);

        // Back-to-back single-word frames
        cur_d = {8'h11};
        send_word(1'b1, 1'b1, 8'h11, 1, 8'h01, 1'b0);
        build_expected(1, 1, 1);
        cur_d = {8'h22};
        send_word(1'b1, 1'b1, 8'h22, 1, 8'h02, 1'b0);
        build_expected(1, 1, 2);
        drain();
        check_frames("t5");

        // Reset in the middle of a frame
        cur_d = {8'h61, 8'h62};
        send_word(1'b1, 1'b0, 8'h61, 6, 8'h77, 1'b0);
        send_word(1'b0, 1'b0, 8'h62, 6, 8'h77, 1'b0);
        ireset = 1'b0;
        #1;
        chk("t6_owrite", 32'(owrite), 32'd0);
        chk("t6_owaddr", 32'(owaddr), 32'd0);
        chk("t6_owdata", 32'(owdata), 32'd0);
        chk("t6_owtag",  32'(owtag),  32'd0);
        chk("t6_obusy",  32'(obusy),  32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge iclk);
            iclkena = ~iclkena;
        end
        iclkena = 1'b0;
        ireset = 1'b1;
        got_q.delete(); exp_q.delete();
        mon_err = 0; exp_err = 0; last_tag = 0;
        isop = 1'b1; ieop = 1'b1; ival = 1'b1; idat = 8'h99; iN = 9'd1; itag = 8'h12;
        for (int k = 0; k < 3; k++) begin
            @(posedge iclk);
            @(negedge iclk);
            chk("t6_hold_write", 32'(owrite), 32'd0);
            chk("t6_hold_busy",  32'(obusy),  32'd0);
        end
        ival = 1'b0; isop = 1'b0; ieop = 1'b0; iclkena = 1'b1;
        @(negedge iclk);
        cur_d = {8'h71, 8'h72, 8'h73};
        send_frame("t6_clean", 3, 3, 8'h13, 1'b0);

        // Full-size frame wraps to the all-ones address
        cur_d.delete();
        for (int i = 0; i < (1 << AW); i++) cur_d.push_back(DW'($urandom));
        send_frame("wrap", 1 << AW, 1 << AW, 8'hEE, 1'b0);

        // Random frames: lengths, N (including illegal), stray words, clock enable
        for (int f = 0; f < 40; f++) begin
            int n, len, tg, sel;
            sel = $urandom_range(0, 9);
            if (sel == 0)      n = 0;
            else if (sel == 1) n = $urandom_range((1 << AW) + 1, (1 << (AW + 1)) - 1);
            else               n = $urandom_range(1, 12);
            len = $urandom_range(1, (n >= 1 && n <= 12) ? n + 3 : 4);
            tg  = $urandom_range(0, 255);
            if ($urandom_range(0, 4) == 0) begin
                send_word(1'b0, 1'b0, DW'($urandom), n, TW'(tg), 1'b0);
                exp_err++;
            end
            cur_d.delete();
            for (int i = 0; i < len; i++) cur_d.push_back(DW'($urandom));
            send_frame("rnd", n, len, tg, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
